// File: rtl/instr_mem_if.sv
// instr_mem_if: fetch/load bus of the instruction memory.
//   master (fetch stage / loader): drives fetch_req, addr, stall, flush,
//                                  prog_mode, load_en, load_addr, load_data
//   slave  (instr_mem)           : drives dout, dout_valid, oob, ready
interface instr_mem_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] addr;
    logic              stall;
    logic              flush;
    logic              prog_mode;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              oob;
    logic              ready;

    modport master (
        output fetch_req, addr, stall, flush, prog_mode, load_en, load_addr, load_data,
        input  dout, dout_valid, oob, ready
    );

    modport slave (
        input  fetch_req, addr, stall, flush, prog_mode, load_en, load_addr, load_data,
        output dout, dout_valid, oob, ready
    );
endinterface

// File: rtl/instr_mem.sv
// instr_mem: writable, synchronous-read instruction memory for the fetch stage.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset (array contents are not reset)
//   bus   - instr_mem_if.slave: fetch request/address, stall, flush,
//           program-mode request, load port; registered dout/dout_valid/oob
//           and ready (high only while in RUN).
// Modes: RUN serves fetches; PROG accepts loads; WARM is a one-cycle gap after
// PROG so the last load is settled before the first fetch.
module instr_mem #(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    instr_mem_if.slave   bus
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PROG = 2'd1,
        ST_WARM = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              oob_q;

    logic              fetch_hit_s;
    logic              load_hit_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] rd_word_s;

    // Range checks, array index extraction and write qualification.
    always_comb begin
        fetch_hit_s = ({1'b0, bus.addr} < DEPTH_C);
        load_hit_s  = ({1'b0, bus.load_addr} < DEPTH_C);
        rd_idx_s    = bus.addr[IDX_W-1:0];
        wr_idx_s    = bus.load_addr[IDX_W-1:0];
        // Out-of-range addresses must never alias onto a truncated index.
        if (fetch_hit_s) begin
            rd_word_s = mem_q[rd_idx_s];
        end else begin
            rd_word_s = NOP;
        end
        // rst_n gating keeps a load coincident with reset release from landing.
        wr_en_s = rst_n && (state_q == ST_PROG) && bus.load_en && load_hit_s;
    end

    // Instruction array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= bus.load_data;
        end
    end

    // Mode FSM with registered fetch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            dout_q       <= NOP;
            dout_valid_q <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.prog_mode) begin
                        // Leaving RUN discards whatever instruction is held.
                        state_q      <= ST_PROG;
                        dout_q       <= NOP;
                        dout_valid_q <= 1'b0;
                        oob_q        <= 1'b0;
                    end else if (bus.flush) begin
                        state_q      <= ST_RUN;
                        dout_q       <= NOP;
                        dout_valid_q <= 1'b0;
                        oob_q        <= 1'b0;
                    end else if (bus.stall) begin
                        state_q      <= ST_RUN;
                        dout_q       <= dout_q;
                        dout_valid_q <= dout_valid_q;
                        oob_q        <= oob_q;
                    end else if (bus.fetch_req) begin
                        state_q      <= ST_RUN;
                        dout_q       <= rd_word_s;
                        dout_valid_q <= 1'b1;
                        oob_q        <= ~fetch_hit_s;
                    end else begin
                        state_q      <= ST_RUN;
                        dout_q       <= NOP;
                        dout_valid_q <= 1'b0;
                        oob_q        <= 1'b0;
                    end
                end
                ST_PROG: begin
                    if (bus.prog_mode) begin
                        state_q <= ST_PROG;
                    end else begin
                        state_q <= ST_WARM;
                    end
                    dout_q       <= NOP;
                    dout_valid_q <= 1'b0;
                    oob_q        <= 1'b0;
                end
                ST_WARM: begin
                    state_q      <= ST_RUN;
                    dout_q       <= NOP;
                    dout_valid_q <= 1'b0;
                    oob_q        <= 1'b0;
                end
                default: begin
                    state_q      <= ST_RUN;
                    dout_q       <= NOP;
                    dout_valid_q <= 1'b0;
                    oob_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.oob        = oob_q;
    assign bus.ready      = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_mem.sv
// Testbench for instr_mem: a DEPTH=14 instance (32-bit words) and a
// parameter-sweep instance (ADDR_W=10, DATA_W=16, DEPTH=1000).
module tb_instr_mem;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instr_mem_if #(.ADDR_W(6),  .DATA_W(32)) if0 ();
    instr_mem_if #(.ADDR_W(10), .DATA_W(16)) if1 ();

    instr_mem #(.ADDR_W(6), .DATA_W(32), .DEPTH(14), .NOP(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );

    instr_mem #(.ADDR_W(10), .DATA_W(16), .DEPTH(1000), .NOP(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] prog_words [14] = '{
        32'h0800_000b, 32'h2008_0042, 32'h2009_0004, 32'h0109_5020,
        32'hac0a_0004, 32'h8c0b_0004, 32'h1140_0002, 32'h2108_ffff,
        32'h0800_0009, 32'h3c01_1001, 32'h0221_8020, 32'h1000_ffff,
        32'h2402_000a, 32'h0000_0000
    };
    logic [31:0] model0 [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        if0.fetch_req = 1'b0; if0.addr = 6'd0; if0.stall = 1'b0; if0.flush = 1'b0;
        if0.prog_mode = 1'b0; if0.load_en = 1'b0; if0.load_addr = 6'd0;
        if0.load_data = 32'h0;
    endtask

    task automatic idle1();
        if1.fetch_req = 1'b0; if1.addr = 10'd0; if1.stall = 1'b0; if1.flush = 1'b0;
        if1.prog_mode = 1'b0; if1.load_en = 1'b0; if1.load_addr = 10'd0;
        if1.load_data = 16'h0;
    endtask

    task automatic test_reset();
        idle0(); idle1();
        rst_n = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if0.dout, if0.dout_valid, if0.oob, if0.ready} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_async: dout=%h v=%b oob=%b rdy=%b, want 0/0/0/1",
                     if0.dout, if0.dout_valid, if0.oob, if0.ready);
        end
        n_vec++;
        if ({if1.dout, if1.dout_valid, if1.oob, if1.ready} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_async_sweep: dout=%h v=%b oob=%b rdy=%b, want 0/0/0/1",
                     if1.dout, if1.dout_valid, if1.oob, if1.ready);
        end
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({if0.dout, if0.dout_valid, if0.oob, if0.ready} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_idle: dout=%h v=%b oob=%b rdy=%b, want 0/0/0/1",
                         if0.dout, if0.dout_valid, if0.oob, if0.ready);
            end
        end
    endtask

    task automatic test_load_run();
        if0.prog_mode = 1'b1;
        tick();
        n_vec++;
        if ({if0.ready, if0.dout_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL prog_enter: rdy=%b v=%b, want 0/0", if0.ready, if0.dout_valid);
        end
        for (int i = 0; i < 13; i++) begin
            if0.load_en = 1'b1; if0.load_addr = 6'(i); if0.load_data = prog_words[i];
            model0[i] = prog_words[i];
            // Fetch-side controls must be ignored while programming.
            if0.fetch_req = 1'($urandom_range(0, 1)); if0.addr = 6'($urandom_range(0, 13));
            if0.flush = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if ({if0.dout, if0.dout_valid, if0.oob, if0.ready} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL prog_outputs: dout=%h v=%b oob=%b rdy=%b, want 0/0/0/0",
                         if0.dout, if0.dout_valid, if0.oob, if0.ready);
            end
        end
        // Final load on the same edge prog_mode drops.
        if0.fetch_req = 1'b0; if0.flush = 1'b0;
        if0.load_addr = 6'd13; if0.load_data = prog_words[13]; model0[13] = prog_words[13];
        if0.prog_mode = 1'b0;
        tick();
        n_vec++;
        if (if0.ready !== 1'b0) begin
            n_err++;
            $display("FAIL warm_ready: rdy=%b, want 0", if0.ready);
        end
        if0.load_en = 1'b0;
        if0.fetch_req = 1'b1; if0.addr = 6'd13;
        tick();
        n_vec++;
        if ({if0.ready, if0.dout_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL run_return: rdy=%b v=%b, want 1/0", if0.ready, if0.dout_valid);
        end
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid, if0.oob} !== {model0[13], 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL last_load_fetch: dout=%h v=%b oob=%b, want %h/1/0",
                     if0.dout, if0.dout_valid, if0.oob, model0[13]);
        end
        for (int i = 0; i < 14; i++) begin
            if0.addr = 6'(i);
            tick();
            n_vec++;
            if ({if0.dout, if0.dout_valid, if0.oob} !== {model0[i], 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: dout=%h v=%b oob=%b, want %h/1/0",
                         i, if0.dout, if0.dout_valid, if0.oob, model0[i]);
            end
        end
        if0.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_stall_flush();
        logic [31:0] e_dout;
        logic        e_v;
        logic        e_oob;
        logic        fr, st, fl;
        logic [5:0]  a;
        if0.fetch_req = 1'b1; if0.addr = 6'd1;
        tick();
        for (int k = 0; k < 3; k++) begin
            if0.stall = 1'b1;
            if0.fetch_req = 1'($urandom_range(0, 1));
            if0.addr = 6'($urandom_range(0, 63));
            tick();
            n_vec++;
            if ({if0.dout, if0.dout_valid, if0.oob} !== {32'h2008_0042, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold: dout=%h v=%b oob=%b, want 20080042/1/0",
                         if0.dout, if0.dout_valid, if0.oob);
            end
        end
        if0.flush = 1'b1;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid, if0.oob} !== {32'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL stall_flush: dout=%h v=%b oob=%b, want 0/0/0",
                     if0.dout, if0.dout_valid, if0.oob);
        end
        if0.stall = 1'b0; if0.flush = 1'b1; if0.fetch_req = 1'b1; if0.addr = 6'd3;
        tick();
        if0.flush = 1'b0; if0.fetch_req = 1'b0;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid} !== {32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_no_replay: dout=%h v=%b, want 0/0", if0.dout, if0.dout_valid);
        end
        // Randomized fetch/stall/flush stream against the priority rules.
        e_dout = 32'h0; e_v = 1'b0; e_oob = 1'b0;
        for (int n = 0; n < 300; n++) begin
            fr = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 6) == 0);
            a  = 6'($urandom_range(0, 20));
            if0.fetch_req = fr; if0.stall = st; if0.flush = fl; if0.addr = a;
            if (fl) begin
                e_dout = 32'h0; e_v = 1'b0; e_oob = 1'b0;
            end else if (st) begin
                e_dout = e_dout;
            end else if (fr && a < 6'd14) begin
                e_dout = model0[a]; e_v = 1'b1; e_oob = 1'b0;
            end else if (fr) begin
                e_dout = 32'h0; e_v = 1'b1; e_oob = 1'b1;
            end else begin
                e_dout = 32'h0; e_v = 1'b0; e_oob = 1'b0;
            end
            tick();
            n_vec++;
            if ({if0.dout, if0.dout_valid, if0.oob} !== {e_dout, e_v, e_oob}) begin
                n_err++;
                $display("FAIL random_fetch[%0d]: dout=%h v=%b oob=%b, want %h/%b/%b",
                         n, if0.dout, if0.dout_valid, if0.oob, e_dout, e_v, e_oob);
            end
        end
        idle0();
        tick();
    endtask

    task automatic test_oob();
        logic [5:0] oaddr [2] = '{6'd20, 6'd63};
        foreach (oaddr[i]) begin
            if0.fetch_req = 1'b1; if0.addr = oaddr[i];
            tick();
            n_vec++;
            if ({if0.dout, if0.dout_valid, if0.oob} !== {32'h0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL oob_fetch[%0d]: dout=%h v=%b oob=%b, want 0/1/1",
                         oaddr[i], if0.dout, if0.dout_valid, if0.oob);
            end
        end
        if0.fetch_req = 1'b0; if0.prog_mode = 1'b1;
        tick();
        if0.load_en = 1'b1; if0.load_addr = 6'd20; if0.load_data = $urandom;
        tick();
        if0.load_en = 1'b0; if0.prog_mode = 1'b0;
        tick(); tick();
        if0.fetch_req = 1'b1; if0.addr = 6'd4;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid, if0.oob} !== {model0[4], 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL oob_load_dropped: dout=%h v=%b oob=%b, want %h/1/0",
                     if0.dout, if0.dout_valid, if0.oob, model0[4]);
        end
        idle0();
        tick();
    endtask

    task automatic test_mode_guard();
        if0.load_en = 1'b1; if0.load_addr = 6'd2; if0.load_data = 32'hffff_ffff;
        tick();
        if0.load_en = 1'b0; if0.fetch_req = 1'b1; if0.addr = 6'd2;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid} !== {32'h2009_0004, 1'b1}) begin
            n_err++;
            $display("FAIL run_load_ignored: dout=%h v=%b, want 20090004/1",
                     if0.dout, if0.dout_valid);
        end
        if0.prog_mode = 1'b1;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid, if0.ready} !== {32'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL prog_discard: dout=%h v=%b rdy=%b, want 0/0/0",
                     if0.dout, if0.dout_valid, if0.ready);
        end
        if0.prog_mode = 1'b0; if0.fetch_req = 1'b0;
        tick();
        // Edge taken while in WARM: load must not land.
        if0.load_en = 1'b1; if0.load_addr = 6'd3; if0.load_data = ~model0[3];
        tick();
        if0.load_en = 1'b0; if0.fetch_req = 1'b1; if0.addr = 6'd3;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid} !== {model0[3], 1'b1}) begin
            n_err++;
            $display("FAIL warm_load_ignored: dout=%h v=%b, want %h/1",
                     if0.dout, if0.dout_valid, model0[3]);
        end
        idle0();
        tick();
    endtask

    task automatic test_reset_midload();
        logic [31:0] r;
        r = $urandom;
        if0.prog_mode = 1'b1;
        tick();
        if0.load_en = 1'b1; if0.load_addr = 6'd5; if0.load_data = r; model0[5] = r;
        tick();
        if0.load_addr = 6'd6; if0.load_data = ~model0[6];
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if0.dout_valid, if0.ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_midload: v=%b rdy=%b, want 0/1", if0.dout_valid, if0.ready);
        end
        if0.prog_mode = 1'b0;
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        if0.load_en = 1'b0; if0.fetch_req = 1'b1; if0.addr = 6'd5;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid} !== {model0[5], 1'b1}) begin
            n_err++;
            $display("FAIL reset_retains: dout=%h v=%b, want %h/1", if0.dout, if0.dout_valid, model0[5]);
        end
        if0.addr = 6'd6;
        tick();
        n_vec++;
        if ({if0.dout, if0.dout_valid} !== {model0[6], 1'b1}) begin
            n_err++;
            $display("FAIL reset_blocks_load: dout=%h v=%b, want %h/1", if0.dout, if0.dout_valid, model0[6]);
        end
        idle0();
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] w0;
        logic [15:0] w999;
        logic [9:0]  a;
        logic [15:0] e;
        w0 = 16'($urandom); w999 = 16'($urandom);
        if1.prog_mode = 1'b1;
        tick();
        if1.load_en = 1'b1; if1.load_addr = 10'd0; if1.load_data = w0;
        tick();
        if1.load_addr = 10'd999; if1.load_data = w999;
        tick();
        if1.load_addr = 10'd1000; if1.load_data = ~w999;
        tick();
        if1.load_en = 1'b0; if1.prog_mode = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 10'd0 : (i == 1) ? 10'd999 : (i == 2) ? 10'd1000 : 10'd1023;
            e = (i == 0) ? w0 : (i == 1) ? w999 : 16'h0;
            if1.fetch_req = 1'b1; if1.addr = a;
            tick();
            n_vec++;
            if ({if1.dout, if1.dout_valid, if1.oob} !== {e, 1'b1, (i >= 2)}) begin
                n_err++;
                $display("FAIL sweep_fetch[%0d]: dout=%h v=%b oob=%b, want %h/1/%b",
                         a, if1.dout, if1.dout_valid, if1.oob, e, (i >= 2));
            end
        end
        idle1();
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        idle0(); idle1();
        test_reset();
        test_load_run();
        test_stall_flush();
        test_oob();
        test_mode_guard();
        test_reset_midload();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
